// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC bits [IDX_W+1:2]. ID performs a combinational lookup; EX trains one
// entry per resolved branch and bumps the resolved/mispredict statistics.
//
// Update handshake: an EX branch is consumed (trained and counted) only in a
// cycle where ex_branch_valid=1, rdy=1 and stall_sign[3]=0. A branch held in
// EX by a stall is therefore consumed exactly once, on the cycle it leaves.
module branch_predictor #(
  parameter int ENTRIES = 128,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_is_branch,
  output logic              id_taken,
  input  logic              ex_branch_valid,
  input  logic [ADDR_W-1:0] ex_branch_pc,
  input  logic              ex_branch_taken,
  input  logic              ex_taken,
  input  logic [STALL_W-1:0] stall_sign,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  logic [1:0]       r_table [ENTRIES];
  logic [31:0]      r_stat_branches;
  logic [31:0]      r_stat_mispred;

  logic [IDX_W-1:0] w_id_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_upd;
  logic [1:0]       w_ex_cur;
  logic [1:0]       w_ex_next;
  logic [1:0]       w_id_ctr;
  logic             w_unused;

  assign w_id_idx = id_pc[IDX_W+1:2];
  assign w_ex_idx = ex_branch_pc[IDX_W+1:2];
  assign w_upd    = ex_branch_valid & rdy & ~stall_sign[3];
  assign w_ex_cur = r_table[w_ex_idx];

  // Tag-less table: upper PC bits and the byte offset never take part.
  assign w_unused = ^{id_pc[ADDR_W-1:IDX_W+2], id_pc[1:0],
                      ex_branch_pc[ADDR_W-1:IDX_W+2], ex_branch_pc[1:0],
                      stall_sign[STALL_W-1:4], stall_sign[2:0]};

  // Saturating step of the EX entry toward the resolved direction.
  always_comb begin
    w_ex_next = w_ex_cur;
    if (ex_branch_taken) begin
      if (w_ex_cur != 2'b11) w_ex_next = w_ex_cur + 2'd1;
    end else begin
      if (w_ex_cur != 2'b00) w_ex_next = w_ex_cur - 2'd1;
    end
  end

  // Lookup with bypass: a same-index update this cycle is seen immediately.
  always_comb begin
    w_id_ctr = r_table[w_id_idx];
    if (w_upd && (w_ex_idx == w_id_idx)) w_id_ctr = w_ex_next;
  end

  assign id_taken = id_is_branch & w_id_ctr[1];

  // Counter table: reset to weak-NT, train one entry per consumed branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= 2'b01;
    end else if (w_upd) begin
      r_table[w_ex_idx] <= w_ex_next;
    end
  end

  // Statistics: both counters wrap modulo 2^32 and move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches <= 32'd0;
      r_stat_mispred  <= 32'd0;
    end else if (w_upd) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (ex_taken != ex_branch_taken) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by a
// random phase, with a reference counter table and statistics model.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] id_pc;
  logic        id_is_branch;
  logic        id_taken;
  logic        ex_branch_valid;
  logic [31:0] ex_branch_pc;
  logic        ex_branch_taken;
  logic        ex_taken;
  logic [5:0]  stall_sign;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:0]  exp_q[$];
  logic [1:0]  mdl_ctr [128];
  logic [31:0] mdl_br;
  logic [31:0] mdl_mis;
  logic [31:0] saved;

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .id_pc           (id_pc),
    .id_is_branch    (id_is_branch),
    .id_taken        (id_taken),
    .ex_branch_valid (ex_branch_valid),
    .ex_branch_pc    (ex_branch_pc),
    .ex_branch_taken (ex_branch_taken),
    .ex_taken        (ex_taken),
    .stall_sign      (stall_sign),
    .stat_branches   (stat_branches),
    .stat_mispred    (stat_mispred)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[8:2]);
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mdl_ctr[i] = 2'b01;
    mdl_br  = 32'd0;
    mdl_mis = 32'd0;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; id_pc = 32'd0; id_is_branch = 1'b0;
    ex_branch_valid = 1'b0; ex_branch_pc = 32'd0;
    ex_branch_taken = 1'b0; ex_taken = 1'b0; stall_sign = 6'd0;
  endtask

  // One cycle, entered just after a negedge. Drives both ports, checks the
  // combinational prediction, then the state after the posedge.
  task automatic step(input logic [31:0] ipc, input logic ibr,
                      input logic ev, input logic [31:0] epc, input logic et,
                      input logic ep, input logic st3, input logic r);
    logic       upd;
    logic [1:0] nxt;
    logic [1:0] e;
    id_pc = ipc; id_is_branch = ibr;
    ex_branch_valid = ev; ex_branch_pc = epc; ex_branch_taken = et;
    ex_taken = ep; stall_sign = {2'b00, st3, 3'b000}; rdy = r;
    upd = ev & r & ~st3;
    nxt = sat(mdl_ctr[idx(epc)], et);
    e   = mdl_ctr[idx(ipc)];
    if (upd && idx(ipc) == idx(epc)) e = nxt;
    exp_q.push_back(ibr & e[1]);
    #1;
    chk("id_taken", {31'd0, id_taken}, {31'd0, exp_q.pop_front()});
    @(posedge clk);
    if (upd) begin
      mdl_ctr[idx(epc)] = nxt;
      mdl_br = mdl_br + 32'd1;
      if (et != ep) mdl_mis = mdl_mis + 32'd1;
    end
    #1;
    chk("stat_branches", stat_branches, mdl_br);
    chk("stat_mispred", stat_mispred, mdl_mis);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic train(input logic [31:0] pc, input logic t);
    step(32'd0, 1'b0, 1'b1, pc, t, 1'b0, 1'b0, 1'b1);
  endtask

  // Lookup only, against a constant taken from the intended behaviour.
  task automatic peek(input string tag, input logic [31:0] pc, input logic br, input logic exp);
    id_pc = pc; id_is_branch = br; ex_branch_valid = 1'b0;
    #1;
    chk(tag, {31'd0, id_taken}, {31'd0, exp});
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_branches", stat_branches, 32'd0);
    chk("rst_mispred", stat_mispred, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Training and saturation at 0x100
    train(32'h100, 1'b1);
    peek("train_10", 32'h100, 1'b1, 1'b1);
    train(32'h100, 1'b1);
    train(32'h100, 1'b1);
    peek("train_sat11", 32'h100, 1'b1, 1'b1);
    train(32'h100, 1'b0);
    peek("nt_10", 32'h100, 1'b1, 1'b1);
    train(32'h100, 1'b0);
    peek("nt_01", 32'h100, 1'b1, 1'b0);
    train(32'h100, 1'b0);
    train(32'h100, 1'b0);
    peek("nt_sat00", 32'h100, 1'b1, 1'b0);
    train(32'h100, 1'b1);
    peek("from00_to01", 32'h100, 1'b1, 1'b0);

    // Bypass: 0x40 at weak-NT, lookup and taken update together
    step(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    peek("bypass_after", 32'h40, 1'b1, 1'b1);
    step(32'h44, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1);
    peek("neighbour_44", 32'h44, 1'b1, 1'b0);

    // Stall: held 3 cycles, trained once when it leaves EX
    saved = stat_branches;
    for (int i = 0; i < 3; i++) step(32'h80, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1);
    step(32'h84, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("stall_once", stat_branches, saved + 32'd1);
    peek("stall_step", 32'h80, 1'b1, 1'b1);
    train(32'h80, 1'b0);
    peek("stall_single", 32'h80, 1'b1, 1'b0);

    // rdy low throughout: nothing moves
    saved = stat_branches;
    for (int i = 0; i < 3; i++) step(32'hC0, 1'b1, 1'b1, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'hC0, 1'b1, 1'b1, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rdy_hold", stat_branches, saved);
    peek("rdy_ctr", 32'hC0, 1'b1, 1'b0);

    // Aliasing: 0x000 and 0x200 share an entry
    train(32'h000, 1'b1);
    train(32'h000, 1'b1);
    peek("alias_200", 32'h200, 1'b1, 1'b1);
    peek("not_branch", 32'h200, 1'b0, 1'b0);

    // Statistics from a clean reset
    rst = 1'b1;
    #2;
    model_reset();
    chk("midrst_branches", stat_branches, 32'd0);
    peek("midrst_lookup", 32'h100, 1'b1, 1'b0);
    rst = 1'b0;
    step(32'h0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("stats_5", stat_branches, 32'd5);
    chk("stats_mis2", stat_mispred, 32'd2);

    // Mispredict counter wrap from all-ones
    force dut.r_stat_mispred = 32'hFFFF_FFFF;
    #1;
    release dut.r_stat_mispred;
    mdl_mis = 32'hFFFF_FFFF;
    chk("preload", stat_mispred, 32'hFFFF_FFFF);
    step(32'h0, 1'b0, 1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mis_wrap", stat_mispred, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ip;
      logic [31:0] ep;
      ip = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      ep = ($urandom_range(0, 3) == 0) ? ip : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      step(ip, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ep,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
    end

    // Reset after random training clears everything
    rst = 1'b1;
    #2;
    model_reset();
    for (int i = 0; i < 8; i++) peek("final_rst_ctr", 32'(i * 64), 1'b1, 1'b0);
    chk("final_rst_br", stat_branches, 32'd0);
    chk("final_rst_mis", stat_mispred, 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
